fifo_rd_stream: RTL and testbench

- Read-side consumer for async_fifo, clocked in the read domain.
- Drains the FIFO read port (rempty/rdata/rinc) into a registered valid/ready stream with a 2-entry output buffer, so rinc never depends combinationally on downstream ready.
- Tags frame boundaries every FRAME_LEN beats and counts completed frames.
- Sits between async_fifo and any read-domain consumer.

---
 rtl/fifo_rd_stream.sv | 59 +++++
 tb/tb_fifo_rd_stream.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a FWFT async_fifo read port into a 2-entry registered valid/ready stream,
// tagging every FRAME_LEN-th beat as last and counting delivered frames.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 16,
  parameter int FCNT_W     = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            level,
  output logic [FCNT_W-1:0]     frame_cnt
);
  localparam int PW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  localparam logic [PW-1:0] POS_MAX = PW'(FRAME_LEN - 1);
  logic [PW-1:0]         pos;
  logic [DATA_WIDTH-1:0] d1;
  logic                  l0, l1, hs, last_in, wr_head, wr_tail, shift;
  // pop request depends only on registers and flush, never on out_ready
  assign rinc      = rrst_n & ~rempty & ~flush & (level != 2'd2);
  assign out_valid = level != 2'd0;
  assign out_last  = out_valid & l0;
  assign hs        = out_valid & out_ready & ~flush;
  assign last_in   = pos == POS_MAX;
  always_comb begin
    wr_head = rinc & ((level == 2'd0) | ((level == 2'd1) & hs));
    wr_tail = rinc & (level == 2'd1) & ~hs;
    shift   = hs & (level == 2'd2);
  end
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      level     <= '0;
      out_data  <= '0;
      l0        <= 1'b0;
      d1        <= '0;
      l1        <= 1'b0;
      pos       <= '0;
      frame_cnt <= '0;
    end else if (flush) begin
      level <= '0;
      l0    <= 1'b0;
      pos   <= '0;
    end else begin
      level <= level + 2'(rinc) - 2'(hs);
      if (rinc) pos <= last_in ? '0 : pos + 1'b1;
      if (wr_head) {out_data, l0} <= {rdata, last_in};
      else if (shift) {out_data, l0} <= {d1, l1};
      if (wr_tail) {d1, l1} <= {rdata, last_in};
      if (hs & l0) frame_cnt <= frame_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed checks of fifo_rd_stream with FRAME_LEN=16 and FRAME_LEN=4/FCNT_W=2
// instances sharing one FIFO model and one set of stimulus.
module tb_fifo_rd_stream;
  logic       rclk = 1'b0, rrst_n = 1'b0, rempty = 1'b1, flush = 1'b0, out_ready = 1'b0;
  logic [7:0] rdata = '0;
  logic       rinc_a, valid_a, last_a, rinc_b, valid_b, last_b;
  logic [7:0] data_a, data_b;
  logic [1:0] level_a, level_b, fcnt_b;
  logic [15:0] fcnt_a;
  logic [7:0] q[$];
  logic [7:0] exp_d[32];
  int n_tests = 0, n_fail = 0, beats, cycles;
  logic [1:0] fb_prev;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DATA_WIDTH(8), .FRAME_LEN(16), .FCNT_W(16)) u_a (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc_a), .flush(flush),
    .out_valid(valid_a), .out_ready(out_ready), .out_data(data_a), .out_last(last_a),
    .level(level_a), .frame_cnt(fcnt_a));
  fifo_rd_stream #(.DATA_WIDTH(8), .FRAME_LEN(4), .FCNT_W(2)) u_b (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc_b), .flush(flush),
    .out_valid(valid_b), .out_ready(out_ready), .out_data(data_b), .out_last(last_b),
    .level(level_b), .frame_cnt(fcnt_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic upd();
    rempty = q.size() == 0;
    rdata  = q.size() != 0 ? q[0] : 8'h00;
    #1;
  endtask

  task automatic tick();
    logic pop;
    @(negedge rclk);
    pop = rinc_a;
    @(posedge rclk);
    if (pop && q.size() != 0) void'(q.pop_front());
    #1;
    upd();
  endtask

  initial begin
    // reset with a word waiting
    out_ready = 1'b1;
    q.push_back(8'hA5);
    upd();
    tick();
    chk("rst_rinc", rinc_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_level", level_a, 0);
    chk("rst_fcnt", fcnt_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_last", last_a, 0);
    rrst_n = 1'b1;
    #1;
    chk("rel_rinc", rinc_a, 1);
    // single word
    tick();
    chk("one_valid", valid_a, 1);
    chk("one_data", data_a, 8'hA5);
    chk("one_level", level_a, 1);
    chk("one_rinc", rinc_a, 0);
    tick();
    chk("one_valid_drop", valid_a, 0);
    chk("one_level0", level_a, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    // streaming 32 words, both frame lengths observed together
    for (int i = 0; i < 32; i++) begin
      exp_d[i] = 8'(i * 37 + 11);
      q.push_back(exp_d[i]);
    end
    upd();
    beats = 0;
    cycles = 0;
    while (beats < 32 && cycles < 100) begin
      tick();
      cycles++;
      if (valid_a) begin
        chk("st_data", data_a, exp_d[beats]);
        chk("st_last16", last_a, (beats % 16) == 15);
        chk("st_last4", last_b, (beats % 4) == 3);
        chk("st_fcnt16", fcnt_a, beats / 16);
        chk("st_fcnt4", fcnt_b, (beats / 4) % 4);
        beats++;
      end
    end
    chk("st_beats", beats, 32);
    chk("st_no_bubble", cycles, 32);
    tick();
    chk("st_fcnt_end", fcnt_a, 2);
    chk("st_fcnt4_end", fcnt_b, 0);
    chk("st_level_end", level_a, 0);
    // backpressure
    out_ready = 1'b0;
    q.push_back(8'h01);
    q.push_back(8'h02);
    q.push_back(8'h03);
    upd();
    tick();
    tick();
    tick();
    chk("bp_level", level_a, 2);
    chk("bp_rinc", rinc_a, 0);
    chk("bp_pops", q.size(), 1);
    chk("bp_data", data_a, 8'h01);
    tick();
    chk("bp_stable", data_a, 8'h01);
    chk("bp_valid", valid_a, 1);
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_order_valid", valid_a, 1);
      chk("bp_order", data_a, 8'(k + 1));
      tick();
    end
    chk("bp_level0", level_a, 0);
    // flush with level=2 and position=2 on the FRAME_LEN=4 instance
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    q.push_back(8'h10);
    q.push_back(8'h11);
    upd();
    tick();
    tick();
    chk("fl_level2", level_b, 2);
    for (int i = 0; i < 4; i++) q.push_back(8'(8'h20 + i));
    upd();
    fb_prev = fcnt_b;
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("fl_rinc", rinc_a, 0);
    tick();
    flush = 1'b0;
    chk("fl_level", level_b, 0);
    chk("fl_valid", valid_b, 0);
    chk("fl_last", last_b, 0);
    chk("fl_fcnt", fcnt_b, fb_prev);
    chk("fl_data_hold", data_b, 8'h10);
    chk("fl_nopop", q.size(), 4);
    beats = 0;
    cycles = 0;
    while (beats < 4 && cycles < 20) begin
      tick();
      cycles++;
      if (valid_b) begin
        chk("fl_data", data_b, 8'(8'h20 + beats));
        chk("fl_lastpos", last_b, beats == 3);
        beats++;
      end
    end
    chk("fl_beats", beats, 4);
    tick();
    chk("fl_fcnt_inc", fcnt_b, fb_prev + 2'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
